// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit CPU: fetch FSM state encoding,
// instruction address width and the reset program counter.
package cpu_pkg;

    localparam int ADDR_W = 16;
    localparam logic [ADDR_W-1:0] RESET_PC = 16'h0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        ISSUE = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/pc_next.sv
// Next-PC selection for the fetch stage: purely combinational.
// Priority is jal, then jcond, then branch, then sequential; all arithmetic
// wraps modulo 2^W because the adders are exactly W bits wide.
module pc_next
    import cpu_pkg::*;
#(
    parameter int W = ADDR_W
) (
    input  logic [W-1:0] pc,
    input  logic [7:0]   disp,
    input  logic [W-1:0] jtarget,
    input  logic         branch,
    input  logic         jcond,
    input  logic         jal,
    output logic [W-1:0] next_pc
);

    localparam logic [W-1:0] ONE = W'(1);

    logic [W-1:0] disp_ext;

    // Sign-extend the 8-bit displacement to the full address width.
    always_comb begin
        disp_ext = {{(W-8){disp[7]}}, disp};
    end

    // Priority-ordered target select; register jumps outrank the relative branch.
    always_comb begin
        next_pc = pc + ONE;
        if (jal) begin
            next_pc = jtarget;
        end else if (jcond) begin
            next_pc = jtarget;
        end else if (branch) begin
            next_pc = pc + disp_ext;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches one word per instruction over a
// req/ack handshake and holds it for the control unit until it is consumed.
// Optional feature macro: IFETCH_REDIRECT_CNT_EN enables the saturating
// taken-redirect counter; without it redirect_cnt is a constant zero.
module instr_fetch_unit
    import cpu_pkg::*;
#(
    parameter int                ADDR_W_P   = ADDR_W,
    parameter logic [ADDR_W_P-1:0] RESET_PC_P = RESET_PC
) (
    input  logic                clk,
    input  logic                rst,
    output logic                imem_req,
    output logic [ADDR_W_P-1:0] imem_addr,
    input  logic                imem_ack,
    input  logic [15:0]         imem_rdata,
    output logic [15:0]         INSTRUCTIONS,
    output logic                instr_valid,
    input  logic                stall,
    input  logic                branch,
    input  logic                jcond,
    input  logic                jal,
    input  logic [7:0]          disp,
    input  logic [ADDR_W_P-1:0] jtarget,
    output logic [ADDR_W_P-1:0] link_pc,
    output logic [15:0]         redirect_cnt
);

    localparam logic [ADDR_W_P-1:0] ONE = ADDR_W_P'(1);

    fetch_state_t        state;
    logic [ADDR_W_P-1:0] pc;
    logic [ADDR_W_P-1:0] next_pc;

    pc_next #(
        .W(ADDR_W_P)
    ) u_pc_next (
        .pc      (pc),
        .disp    (disp),
        .jtarget (jtarget),
        .branch  (branch),
        .jcond   (jcond),
        .jal     (jal),
        .next_pc (next_pc)
    );

    // The fetch address is always the PC; it only moves when leaving ISSUE.
    assign imem_addr = pc;

    // Fetch FSM with registered handshake, instruction and link outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            pc           <= RESET_PC_P;
            imem_req     <= 1'b0;
            INSTRUCTIONS <= 16'h0000;
            instr_valid  <= 1'b0;
            link_pc      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    state    <= REQ;
                    imem_req <= 1'b1;
                end
                REQ: begin
                    if (imem_ack) begin
                        INSTRUCTIONS <= imem_rdata;
                        link_pc      <= pc + ONE;
                        instr_valid  <= 1'b1;
                        imem_req     <= 1'b0;
                        state        <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (!stall) begin
                        pc          <= next_pc;
                        instr_valid <= 1'b0;
                        imem_req    <= 1'b1;
                        state       <= REQ;
                    end
                end
                default: begin
                    state       <= IDLE;
                    imem_req    <= 1'b0;
                    instr_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef IFETCH_REDIRECT_CNT_EN
    logic        redirect_taken;
    logic [15:0] cnt;

    assign redirect_taken = (state == ISSUE) && !stall && (jal || jcond || branch);
    assign redirect_cnt   = cnt;

    // Count taken redirects, sticking at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= 16'h0000;
        end else if (redirect_taken && (cnt != 16'hFFFF)) begin
            cnt <= cnt + 16'd1;
        end
    end
`else
    assign redirect_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios followed by
// randomized traffic, compared every cycle against a transaction-level model.
module tb_instr_fetch_unit;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic [15:0] INSTRUCTIONS;
    logic        instr_valid;
    logic        stall;
    logic        branch;
    logic        jcond;
    logic        jal;
    logic [7:0]  disp;
    logic [15:0] jtarget;
    logic [15:0] link_pc;
    logic [15:0] redirect_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model: phase 0 = waiting one cycle after reset, 1 = fetch
    // outstanding, 2 = instruction held for the control unit.
    int m_phase;
    int m_pc;
    int m_instr;
    int m_link;
    int m_cnt;

    instr_fetch_unit dut (
        .clk          (clk),
        .rst          (rst),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .INSTRUCTIONS (INSTRUCTIONS),
        .instr_valid  (instr_valid),
        .stall        (stall),
        .branch       (branch),
        .jcond        (jcond),
        .jal          (jal),
        .disp         (disp),
        .jtarget      (jtarget),
        .link_pc      (link_pc),
        .redirect_cnt (redirect_cnt)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", tag, actual, expected);
        end
    endtask

    // Advance the model by one clock using the inputs the DUT sees at that edge.
    task automatic modelStep();
        int target;
        if (rst) begin
            m_phase = 0; m_pc = 0; m_instr = 0; m_link = 0; m_cnt = 0;
        end else if (m_phase == 0) begin
            m_phase = 1;
        end else if (m_phase == 1) begin
            if (imem_ack) begin
                m_instr = int'(imem_rdata);
                m_link  = (m_pc + 1) % 65536;
                m_phase = 2;
            end
        end else if (!stall) begin
            if (jal || jcond) target = int'(jtarget);
            else if (branch) target = (m_pc + int'($signed(disp)) + 65536) % 65536;
            else target = (m_pc + 1) % 65536;
`ifdef IFETCH_REDIRECT_CNT_EN
            if ((jal || jcond || branch) && m_cnt < 65535) m_cnt = m_cnt + 1;
`endif
            m_pc    = target;
            m_phase = 1;
        end
    endtask

    task automatic compareAll();
        checkOutput("imem_req",     32'(imem_req),     32'(m_phase == 1));
        checkOutput("imem_addr",    32'(imem_addr),    32'(m_pc));
        checkOutput("instr_valid",  32'(instr_valid),  32'(m_phase == 2));
        checkOutput("INSTRUCTIONS", 32'(INSTRUCTIONS), 32'(m_instr));
        checkOutput("link_pc",      32'(link_pc),      32'(m_link));
        checkOutput("redirect_cnt", 32'(redirect_cnt), 32'(m_cnt));
    endtask

    // Drive one cycle of inputs, clock it, update the model and compare after the edge.
    task automatic applyStimulus(input logic r, input logic ack, input logic [15:0] rd,
                                 input logic st, input logic br, input logic jc, input logic jl,
                                 input logic [7:0] d, input logic [15:0] jt);
        rst = r; imem_ack = ack; imem_rdata = rd; stall = st;
        branch = br; jcond = jc; jal = jl; disp = d; jtarget = jt;
        @(posedge clk);
        modelStep();
        #1;
        compareAll();
    endtask

    initial begin
        rst = 1'b1; imem_ack = 1'b0; imem_rdata = '0; stall = 1'b0;
        branch = 1'b0; jcond = 1'b0; jal = 1'b0; disp = '0; jtarget = '0;
        m_phase = 0; m_pc = 0; m_instr = 0; m_link = 0; m_cnt = 0;

        // Reset state.
        applyStimulus(1, 0, 16'h0, 0, 0, 0, 0, 8'h00, 16'h0);
        applyStimulus(1, 0, 16'h0, 0, 0, 0, 0, 8'h00, 16'h0);
        checkOutput("reset_req", 32'(imem_req), 32'h0);
        checkOutput("reset_addr", 32'(imem_addr), 32'h0);

        // Idle cycle, then first request at address 0.
        applyStimulus(0, 0, 16'h0, 0, 0, 0, 0, 8'h00, 16'h0);
        checkOutput("first_req", 32'(imem_req), 32'h1);

        // Sequential fetch of 0, 1, 2 with immediate ack.
        applyStimulus(0, 1, 16'hA001, 0, 0, 0, 0, 8'h00, 16'h0);
        checkOutput("seq_instr0", 32'(INSTRUCTIONS), 32'hA001);
        checkOutput("seq_link0", 32'(link_pc), 32'h0001);
        applyStimulus(0, 0, 16'h0, 0, 0, 0, 0, 8'h00, 16'h0);
        checkOutput("seq_addr1", 32'(imem_addr), 32'h0001);
        applyStimulus(0, 1, 16'hA002, 0, 0, 0, 0, 8'h00, 16'h0);
        applyStimulus(0, 0, 16'h0, 0, 0, 0, 0, 8'h00, 16'h0);
        checkOutput("seq_addr2", 32'(imem_addr), 32'h0002);
        applyStimulus(0, 1, 16'hA003, 0, 0, 0, 0, 8'h00, 16'h0);
        checkOutput("seq_link2", 32'(link_pc), 32'h0003);

        // Backward branch from 2 by -4 wraps to FFFE, then FFFF, then 0000.
        applyStimulus(0, 0, 16'h0, 0, 1, 0, 0, 8'hFC, 16'h0);
        checkOutput("branch_wrap", 32'(imem_addr), 32'hFFFE);
        applyStimulus(0, 1, 16'hB000, 0, 0, 0, 0, 8'h00, 16'h0);
        applyStimulus(0, 0, 16'h0, 0, 0, 0, 0, 8'h00, 16'h0);
        checkOutput("addr_ffff", 32'(imem_addr), 32'hFFFF);
        applyStimulus(0, 1, 16'hB001, 0, 0, 0, 0, 8'h00, 16'h0);
        checkOutput("link_wrap", 32'(link_pc), 32'h0000);
        applyStimulus(0, 0, 16'h0, 0, 0, 0, 0, 8'h00, 16'h0);
        checkOutput("addr_wrap", 32'(imem_addr), 32'h0000);

        // jal and branch together: jal target wins, counter steps once.
        applyStimulus(0, 1, 16'hB002, 0, 0, 0, 0, 8'h00, 16'h0);
        applyStimulus(0, 0, 16'h0, 0, 1, 0, 1, 8'h10, 16'h1234);
        checkOutput("jal_prio", 32'(imem_addr), 32'h1234);
`ifdef IFETCH_REDIRECT_CNT_EN
        checkOutput("cnt_two", 32'(redirect_cnt), 32'h2);
`else
        checkOutput("cnt_off", 32'(redirect_cnt), 32'h0);
`endif

        // Jump to 0x0010 and hold the request 3 cycles before ack.
        applyStimulus(0, 1, 16'hC000, 0, 0, 0, 0, 8'h00, 16'h0);
        applyStimulus(0, 0, 16'h0, 0, 0, 1, 0, 8'h00, 16'h0010);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 16'hDEAD, 0, 1, 1, 1, 8'h55, 16'h7777);
            checkOutput("wait_addr", 32'(imem_addr), 32'h0010);
        end
        applyStimulus(0, 1, 16'hC010, 0, 0, 0, 0, 8'h00, 16'h0);
        checkOutput("late_valid", 32'(instr_valid), 32'h1);

        // Stall for 5 cycles with jcond pulsing; jump only when stall drops.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 1, 16'hEEEE, 1, 0, 1'(i % 2 == 0), 0, 8'h00, 16'h5555);
            checkOutput("stall_instr", 32'(INSTRUCTIONS), 32'hC010);
        end
        applyStimulus(0, 0, 16'h0, 0, 0, 1, 0, 8'h00, 16'h0040);
        checkOutput("stall_jump", 32'(imem_addr), 32'h0040);

        // Reset coinciding with ack discards the data.
        applyStimulus(1, 1, 16'hFACE, 0, 0, 0, 0, 8'h00, 16'h0);
        checkOutput("rst_instr", 32'(INSTRUCTIONS), 32'h0);
        checkOutput("rst_valid", 32'(instr_valid), 32'h0);
        applyStimulus(0, 0, 16'h0, 0, 0, 0, 0, 8'h00, 16'h0);
        checkOutput("rst_refetch", 32'(imem_addr), 32'h0);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            applyStimulus(1'($urandom_range(0, 63) == 0),
                          1'($urandom_range(0, 1)),
                          16'($urandom),
                          1'($urandom_range(0, 2) == 0),
                          1'($urandom_range(0, 3) == 0),
                          1'($urandom_range(0, 3) == 0),
                          1'($urandom_range(0, 5) == 0),
                          8'($urandom),
                          16'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch stage of the 16-bit CPU. Owns the program counter, fetches one 16-bit word per instruction from instruction memory over a request/acknowledge handshake, and presents it to the control unit's `INSTRUCTIONS` input. It consumes the control unit's `branch`, `jcond` and `jal` outputs to redirect the PC. It also provides the return address for JAL.

## Interface
- `ADDR_W`, 16, instruction address width; the PC is a word address.
- `RESET_PC`, 16'h0000, PC value loaded on reset.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `imem_req` out 1: fetch request to instruction memory.
- `imem_addr` out ADDR_W: word address of the fetch; equals the PC.
- `imem_ack` in 1: memory accepts the request; `imem_rdata` is valid in the same cycle.
- `imem_rdata` in 16: fetched instruction word.
- `INSTRUCTIONS` out 16: registered instruction, drives the control unit.
- `instr_valid` out 1: `INSTRUCTIONS` holds a live instruction.
- `stall` in 1: downstream is not ready; hold the current instruction.
- `branch` in 1: take a PC-relative branch.
- `jcond` in 1: take a conditional register jump.
- `jal` in 1: take a jump-and-link.
- `disp` in 8: branch displacement, two's complement (the control unit's `R2_im`).
- `jtarget` in ADDR_W: register-sourced jump target.
- `link_pc` out ADDR_W: address of the current instruction + 1, for JAL writeback.
- `redirect_cnt` out 16: count of taken redirects (see Configuration).

## Operation
- FSM states:
  - IDLE: entered on reset. Always moves to REQ on the next cycle.
  - REQ: `imem_req`=1 and `imem_addr`=pc. On `imem_ack`:
    - capture `imem_rdata` into `INSTRUCTIONS`;
    - capture pc+1 into `link_pc`;
    - move to ISSUE.
    - Without ack, stay in REQ and hold the address stable.
  - ISSUE: `instr_valid`=1 and `imem_req`=0.
    - If `stall`=1: hold everything.
    - If `stall`=0: load the next pc and go to REQ.
- Next-PC selection in ISSUE, in priority order:
  - `jal` → `jtarget`
  - `jcond` → `jtarget`
  - `branch` → pc + sign_extend(`disp`)
  - otherwise → pc+1
- Arithmetic is modulo 2^ADDR_W:
  - 16'hFFFF+1 wraps to 16'h0000.
  - pc 16'h0002 with disp 8'hFC gives 16'hFFFE.
- Redirect inputs are sampled only in ISSUE with `stall`=0. They are ignored in all other states and cycles.
- `imem_ack` is ignored outside REQ.
- `INSTRUCTIONS` and `link_pc` are not updated while in REQ. They keep the previous values, with `instr_valid`=0.

## Timing
- Reset values:
  - pc = RESET_PC
  - state = IDLE
  - `imem_req`=0
  - `imem_addr`=RESET_PC
  - `INSTRUCTIONS`=16'h0000
  - `instr_valid`=0
  - `link_pc`=16'h0000
  - `redirect_cnt`=0
- First request: `imem_req` rises in the 2nd cycle after `rst` is released (cycle 1 is IDLE, cycle 2 is REQ).
- Latency: ack in cycle N → `instr_valid`=1 in cycle N+1. The next REQ comes in cycle N+2 at the earliest.
- Throughput: at best one instruction every 2 cycles.
- Redirect takes effect immediately: the REQ following an ISSUE with a taken redirect carries the target address. There is no wrong-path fetch.
- `rst` during REQ or ISSUE: return to IDLE with reset values. A same-cycle `imem_ack` is discarded.
- Simultaneous `jal` and `branch`: `jal` wins. The counter increments by exactly 1.

## Configuration
- `IFETCH_REDIRECT_CNT_EN` defined:
  - `redirect_cnt` increments by 1 on each ISSUE cycle with `stall`=0 and any of `jal`/`jcond`/`branch` set.
  - It saturates at 16'hFFFF.
  - It clears on `rst`.
- Not defined: `redirect_cnt` is tied to 16'h0000 and no counter register exists.

## Structure
- Shared package `cpu_pkg` holds:
  - the FSM state encoding (IDLE, REQ, ISSUE);
  - `ADDR_W`;
  - the reset PC constant.
- One sub-module, `pc_next`: purely combinational next-PC mux and adder (priority select, sign extension, wrap). The FSM and registers stay in `instr_fetch_unit`.

## Test plan
- Reset then sequential fetch with ack on the first REQ cycle → `imem_addr` 0x0000, 0x0001, 0x0002. `INSTRUCTIONS` follows `imem_rdata` one cycle after each ack. `link_pc`=0x0001, 0x0002, 0x0003.
- Ack delayed by 3 cycles at addr 0x0010 → `imem_req` held high and addr stable for 4 cycles. `instr_valid` stays 0 until the cycle after ack.
- Branch in ISSUE at pc 0x0002 with `disp`=8'hFC → next `imem_addr`=0xFFFE. A later fetch at 0xFFFF then fetches 0x0000.
- `jal`=1 and `branch`=1 together, `jtarget`=0x1234, `stall`=0 → next address 0x1234. `redirect_cnt` +1 with the macro, 0 without.
- `stall`=1 for 5 cycles in ISSUE with `jcond`=1 pulsing → no request and `INSTRUCTIONS` unchanged. The jump is taken only on the cycle `stall` drops with `jcond` high.
- `rst` asserted in the same cycle as `imem_ack` in REQ → ack data discarded. All outputs return to reset values, and the next request is at `RESET_PC`.
